hazard_unit_param: RTL and testbench

- Parametrised successor of the pipeline hazard unit for the F/F2/D/E/M/M2/W core.
- Forwarding depth, source-operand count and register-address width are parameters.
- Adds a long-latency writeback scoreboard for mul/div/cp0-slow ops, a saturating stall-cycle counter and a sticky stall-watchdog error flag.
- Sits beside the datapath: it drives the per-stage stall/flush signals and the decode-stage forwarding selects.

---
 rtl/hazard_unit_param_if.sv | 50 +++++
 rtl/hazard_unit_param.sv | 114 +++++++++++
 tb/tb_hazard_unit_param.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_param_if.sv
// Hazard-unit bundle: pipeline status and long-latency op events in,
// stall/flush controls, forward selects and health counters out.
interface hazard_unit_param_if #(
  parameter int NSTG = 4,
  parameter int NSRC = 2,
  parameter int AW   = 5
);
  localparam int SW = $clog2(NSTG + 1);

  logic                 i_cache_stall, d_cache_stall, alu_stallE, blank_sl;
  logic                 flush_exceptionM, flush_pred_failedM;
  logic                 jumpD, branchD, pred_takeD, branchM, pre_right;
  logic [NSRC*AW-1:0]   srcD;
  logic [NSTG-1:0]      wen_stg;
  logic [NSTG*AW-1:0]   waddr_stg;
  logic [NSTG-1:0]      notready_stg;
  logic                 lop_issue, lop_done, lop_kill;
  logic [AW-1:0]        lop_dst, lop_done_dst;

  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 stallF, stallF2, stallD, stallE, stallM, stallM2, stallW;
  logic                 flushF, flushF2, flushD, flushE, flushM, flushM2, flushW;
  logic                 stallDblank, longest_stall, icache_ctl;
  logic [31:0]          stall_cnt;
  logic                 hang_err;

  modport slave (
    input  i_cache_stall, d_cache_stall, alu_stallE, blank_sl,
    input  flush_exceptionM, flush_pred_failedM,
    input  jumpD, branchD, pred_takeD, branchM, pre_right,
    input  srcD, wen_stg, waddr_stg, notready_stg,
    input  lop_issue, lop_done, lop_kill, lop_dst, lop_done_dst,
    output fwd_sel,
    output stallF, stallF2, stallD, stallE, stallM, stallM2, stallW,
    output flushF, flushF2, flushD, flushE, flushM, flushM2, flushW,
    output stallDblank, longest_stall, icache_ctl, stall_cnt, hang_err
  );

  modport master (
    output i_cache_stall, d_cache_stall, alu_stallE, blank_sl,
    output flush_exceptionM, flush_pred_failedM,
    output jumpD, branchD, pred_takeD, branchM, pre_right,
    output srcD, wen_stg, waddr_stg, notready_stg,
    output lop_issue, lop_done, lop_kill, lop_dst, lop_done_dst,
    input  fwd_sel,
    input  stallF, stallF2, stallD, stallE, stallM, stallM2, stallW,
    input  flushF, flushF2, flushD, flushE, flushM, flushM2, flushW,
    input  stallDblank, longest_stall, icache_ctl, stall_cnt, hang_err
  );
endinterface

// File: rtl/hazard_unit_param.sv
// Parametrised pipeline hazard unit: decode forwarding selects, stall/flush
// generation, long-latency scoreboard, stall counter and stall watchdog.
module hazard_unit_param #(
  parameter int NSTG = 4,
  parameter int NSRC = 2,
  parameter int AW   = 5,
  parameter int WDOG = 1024
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_param_if.slave hz
);
  localparam int SW   = $clog2(NSTG + 1);
  localparam int NREG = 1 << AW;
  localparam int RW   = $clog2(WDOG + 1);

  logic [NSRC*SW-1:0] fwd_sel_w;
  logic [NSRC-1:0]    ld_use_src, sb_hit_src;
  logic [NREG-1:0]    sb_q, sb_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [RW-1:0]      run_q, run_d;
  logic               hang_q, hang_d;
  logic               stall_dblank, cs, longest, stall_dec, stall_exe, branch_ok;

  // Per operand: youngest matching producer wins, so scan oldest-first and overwrite.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic [AW-1:0] src;
      logic [SW-1:0] sel;
      logic          nr;

      assign src = hz.srcD[gi*AW +: AW];

      always_comb begin
        sel = '0;
        nr  = 1'b0;
        for (int i = NSTG - 1; i >= 0; i--) begin
          if (src != '0 && hz.wen_stg[i] && hz.waddr_stg[i*AW +: AW] == src) begin
            sel = SW'(NSTG - i);
            nr  = hz.notready_stg[i];
          end
        end
      end

      assign fwd_sel_w[gi*SW +: SW] = sel;
      assign ld_use_src[gi]         = nr;
      assign sb_hit_src[gi]         = (src != '0) & sb_q[src];
    end
  endgenerate

  assign stall_dblank = (|ld_use_src) | (|sb_hit_src);
  assign cs           = hz.i_cache_stall | hz.d_cache_stall;
  assign longest      = cs | hz.alu_stallE;
  assign stall_dec    = longest | stall_dblank | hz.blank_sl;
  assign stall_exe    = longest | hz.blank_sl;
  assign branch_ok    = (~hz.branchM | hz.pre_right) & hz.branchD & hz.pred_takeD;

  assign hz.fwd_sel       = fwd_sel_w;
  assign hz.stallDblank   = stall_dblank;
  assign hz.longest_stall = longest;
  assign hz.icache_ctl    = hz.d_cache_stall | hz.alu_stallE | stall_dblank | hz.blank_sl;

  assign hz.stallF  = ~hz.flush_exceptionM & stall_dec;
  assign hz.stallF2 = stall_dec;
  assign hz.stallD  = stall_dec;
  assign hz.stallE  = stall_exe;
  assign hz.stallM  = stall_exe;
  assign hz.stallM2 = longest;
  assign hz.stallW  = ~hz.flush_exceptionM & longest;

  assign hz.flushF  = 1'b0;
  assign hz.flushF2 = hz.flush_exceptionM | hz.flush_pred_failedM
                    | ((hz.jumpD | branch_ok) & ~stall_dec);
  assign hz.flushD  = hz.flush_exceptionM | hz.flush_pred_failedM;
  assign hz.flushE  = hz.flush_exceptionM | ((hz.flush_pred_failedM | stall_dblank) & ~stall_exe);
  assign hz.flushM  = hz.flush_exceptionM;
  assign hz.flushM2 = hz.flush_exceptionM | (hz.blank_sl & ~longest);
  assign hz.flushW  = 1'b0;

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.hang_err  = hang_q;

  // Issue is applied after done so a same-register set/clear leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (hz.lop_kill) begin
      sb_d = '0;
    end else begin
      if (hz.lop_done) sb_d[hz.lop_done_dst] = 1'b0;
      if (hz.lop_issue && hz.lop_dst != '0) sb_d[hz.lop_dst] = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_dec && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;

    run_d = '0;
    if (stall_dec) run_d = (run_q == RW'(WDOG)) ? run_q : run_q + RW'(1);
    hang_d = hang_q | (run_d == RW'(WDOG));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      hang_q      <= 1'b0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      hang_q      <= hang_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit_param.sv
// Randomized and directed bench for hazard_unit_param against a behavioural model.
module tb_hazard_unit_param;
  localparam int NSTG = 4;
  localparam int NSRC = 2;
  localparam int AW   = 5;
  localparam int WDOG = 1024;
  localparam int SW   = $clog2(NSTG + 1);
  localparam int NREG = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_param_if #(.NSTG(NSTG), .NSRC(NSRC), .AW(AW)) hz ();

  hazard_unit_param #(.NSTG(NSTG), .NSRC(NSRC), .AW(AW), .WDOG(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state
  bit      sb_m [NREG];
  longint  cnt_m;
  int      run_m;
  bit      hang_m;

  // Model combinational expectations
  logic [NSRC*SW-1:0] exp_fwd;
  logic [6:0]         exp_stall, exp_flush;
  logic               exp_dblank, exp_longest, exp_icache, exp_stallD;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_comb();
    bit ld, sbh, cs, lng, sdec, sexe, bok;
    ld  = 0;
    sbh = 0;
    exp_fwd = '0;
    for (int j = 0; j < NSRC; j++) begin
      int src, sel;
      src = int'(hz.srcD[j*AW +: AW]);
      sel = 0;
      if (src != 0) begin
        for (int i = 0; i < NSTG; i++) begin
          if (sel == 0 && hz.wen_stg[i] && int'(hz.waddr_stg[i*AW +: AW]) == src) begin
            sel = NSTG - i;
            if (hz.notready_stg[i]) ld = 1;
          end
        end
        if (sb_m[src]) sbh = 1;
      end
      exp_fwd[j*SW +: SW] = SW'(sel);
    end
    exp_dblank  = ld | sbh;
    cs          = hz.i_cache_stall | hz.d_cache_stall;
    lng         = cs | hz.alu_stallE;
    exp_longest = lng;
    exp_icache  = hz.d_cache_stall | hz.alu_stallE | exp_dblank | hz.blank_sl;
    sdec        = lng | exp_dblank | hz.blank_sl;
    sexe        = lng | hz.blank_sl;
    exp_stallD  = sdec;
    bok         = (~hz.branchM | hz.pre_right) & hz.branchD & hz.pred_takeD;
    exp_stall   = {~hz.flush_exceptionM & sdec, sdec, sdec, sexe, sexe, lng,
                   ~hz.flush_exceptionM & lng};
    exp_flush   = {1'b0,
                   hz.flush_exceptionM | hz.flush_pred_failedM | ((hz.jumpD | bok) & ~sdec),
                   hz.flush_exceptionM | hz.flush_pred_failedM,
                   hz.flush_exceptionM | ((hz.flush_pred_failedM | exp_dblank) & ~sexe),
                   hz.flush_exceptionM,
                   hz.flush_exceptionM | (hz.blank_sl & ~lng),
                   1'b0};
  endtask

  // Settle inputs and compare all combinational outputs.
  task automatic apply();
    #1;
    model_comb();
    check("fwd_sel", 64'(hz.fwd_sel), 64'(exp_fwd));
    check("stalls", 64'({hz.stallF, hz.stallF2, hz.stallD, hz.stallE, hz.stallM, hz.stallM2, hz.stallW}),
          64'(exp_stall));
    check("flushes", 64'({hz.flushF, hz.flushF2, hz.flushD, hz.flushE, hz.flushM, hz.flushM2, hz.flushW}),
          64'(exp_flush));
    check("stallDblank", 64'(hz.stallDblank), 64'(exp_dblank));
    check("longest_stall", 64'(hz.longest_stall), 64'(exp_longest));
    check("icache_ctl", 64'(hz.icache_ctl), 64'(exp_icache));
  endtask

  // Clock edge: advance model state, then compare registered outputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) sb_m[r] = 0;
      cnt_m  = 0;
      run_m  = 0;
      hang_m = 0;
    end else begin
      if (hz.lop_kill) begin
        for (int r = 0; r < NREG; r++) sb_m[r] = 0;
      end else begin
        if (hz.lop_done) sb_m[int'(hz.lop_done_dst)] = 0;
        if (hz.lop_issue && hz.lop_dst != 0) sb_m[int'(hz.lop_dst)] = 1;
      end
      if (exp_stallD) begin
        if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
        run_m++;
      end else begin
        run_m = 0;
      end
      if (run_m >= WDOG) hang_m = 1;
    end
    #1;
    check("stall_cnt", 64'(hz.stall_cnt), 64'(cnt_m));
    check("hang_err", 64'(hz.hang_err), 64'(hang_m));
    $display("cyc %0d rst=%0b stallD=%0b dblank=%0b fwd=%0h cnt=%0d hang=%0b",
             cyc, rst, hz.stallD, hz.stallDblank, hz.fwd_sel, hz.stall_cnt, hz.hang_err);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 0;
    hz.i_cache_stall = 0; hz.d_cache_stall = 0; hz.alu_stallE = 0; hz.blank_sl = 0;
    hz.flush_exceptionM = 0; hz.flush_pred_failedM = 0;
    hz.jumpD = 0; hz.branchD = 0; hz.pred_takeD = 0; hz.branchM = 0; hz.pre_right = 0;
    hz.srcD = '0; hz.wen_stg = '0; hz.waddr_stg = '0; hz.notready_stg = '0;
    hz.lop_issue = 0; hz.lop_done = 0; hz.lop_kill = 0; hz.lop_dst = '0; hz.lop_done_dst = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    apply(); tick();
    apply(); tick();
    rst = 0;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) sb_m[r] = 0;
    cnt_m = 0; run_m = 0; hang_m = 0;
    clear_inputs();
    @(negedge clk);
    do_reset();
    check("rst_stall_cnt", 64'(hz.stall_cnt), 64'd0);
    check("rst_hang_err", 64'(hz.hang_err), 64'd0);

    // E forwarding and load-use
    hz.wen_stg = 4'b0001; hz.waddr_stg[4:0] = 5'd5; hz.srcD[4:0] = 5'd5;
    apply();
    check("tp_fwd_E", 64'(hz.fwd_sel[SW-1:0]), 64'd4);
    check("tp_no_dblank", 64'(hz.stallDblank), 64'd0);
    tick();
    hz.notready_stg = 4'b0001;
    apply();
    check("tp_ld_use", 64'({hz.stallDblank, hz.stallF, hz.stallD, hz.flushE, hz.stallE}), 64'b11110);
    tick();

    // Youngest writer wins; r0 never forwards
    clear_inputs();
    hz.wen_stg = 4'b1010; hz.waddr_stg[1*AW +: AW] = 5'd7; hz.waddr_stg[3*AW +: AW] = 5'd7;
    hz.srcD[4:0] = 5'd7;
    apply();
    check("tp_fwd_M", 64'(hz.fwd_sel[SW-1:0]), 64'd3);
    tick();
    clear_inputs();
    hz.wen_stg = 4'b0001;
    apply();
    check("tp_fwd_r0", 64'(hz.fwd_sel[SW-1:0]), 64'd0);
    tick();

    // Scoreboard set, clear, same-cycle set/clear
    clear_inputs();
    hz.lop_issue = 1; hz.lop_dst = 5'd9;
    apply(); tick();
    clear_inputs();
    hz.srcD[4:0] = 5'd9; hz.lop_done = 1; hz.lop_done_dst = 5'd9;
    apply();
    check("tp_sb_set", 64'(hz.stallDblank), 64'd1);
    tick();
    hz.lop_done = 0;
    apply();
    check("tp_sb_clr", 64'(hz.stallDblank), 64'd0);
    tick();
    hz.lop_issue = 1; hz.lop_dst = 5'd9; hz.lop_done = 1; hz.lop_done_dst = 5'd9;
    apply(); tick();
    hz.lop_issue = 0; hz.lop_done = 0;
    apply();
    check("tp_sb_setwins", 64'(hz.stallDblank), 64'd1);
    tick();

    // Kill and r0 issue
    clear_inputs();
    hz.lop_issue = 1; hz.lop_dst = 5'd3;
    apply(); tick();
    hz.lop_issue = 0; hz.lop_kill = 1;
    apply(); tick();
    clear_inputs();
    hz.srcD[4:0] = 5'd3; hz.srcD[9:5] = 5'd9;
    apply();
    check("tp_sb_kill", 64'(hz.stallDblank), 64'd0);
    tick();
    hz.lop_issue = 1; hz.lop_dst = 5'd0;
    apply(); tick();
    hz.lop_issue = 0; hz.srcD = '0;
    apply();
    check("tp_sb_r0", 64'(hz.stallDblank), 64'd0);
    tick();

    // Exception flush during an icache stall; jump held off by stall
    clear_inputs();
    hz.flush_exceptionM = 1; hz.i_cache_stall = 1;
    apply();
    check("tp_exc", 64'({hz.stallF, hz.stallW, hz.flushD, hz.flushE, hz.flushM}), 64'b00111);
    tick();
    clear_inputs();
    hz.jumpD = 1; hz.i_cache_stall = 1;
    apply();
    check("tp_jump_stalled", 64'(hz.flushF2), 64'd0);
    tick();
    hz.i_cache_stall = 0;
    apply();
    check("tp_jump_free", 64'(hz.flushF2), 64'd1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      clear_inputs();
      rst                   = ($urandom_range(0, 149) == 0);
      hz.i_cache_stall      = ($urandom_range(0, 7) == 0);
      hz.d_cache_stall      = ($urandom_range(0, 7) == 0);
      hz.alu_stallE         = ($urandom_range(0, 9) == 0);
      hz.blank_sl           = ($urandom_range(0, 7) == 0);
      hz.flush_exceptionM   = ($urandom_range(0, 15) == 0);
      hz.flush_pred_failedM = ($urandom_range(0, 9) == 0);
      hz.jumpD              = ($urandom_range(0, 5) == 0);
      hz.branchD            = $urandom_range(0, 1) == 1;
      hz.pred_takeD         = $urandom_range(0, 1) == 1;
      hz.branchM            = $urandom_range(0, 1) == 1;
      hz.pre_right          = $urandom_range(0, 1) == 1;
      for (int j = 0; j < NSRC; j++) hz.srcD[j*AW +: AW] = AW'($urandom_range(0, 7));
      for (int i = 0; i < NSTG; i++) begin
        hz.waddr_stg[i*AW +: AW] = AW'($urandom_range(0, 7));
        hz.wen_stg[i]            = $urandom_range(0, 1) == 1;
        hz.notready_stg[i]       = ($urandom_range(0, 3) == 0);
      end
      hz.lop_issue    = ($urandom_range(0, 3) == 0);
      hz.lop_dst      = AW'($urandom_range(0, 7));
      hz.lop_done     = ($urandom_range(0, 3) == 0);
      hz.lop_done_dst = AW'($urandom_range(0, 7));
      hz.lop_kill     = ($urandom_range(0, 31) == 0);
      apply(); tick();
    end

    // Watchdog boundary
    do_reset();
    hz.d_cache_stall = 1;
    for (int n = 0; n < WDOG - 1; n++) begin
      apply(); tick();
    end
    check("wd_pre_hang", 64'(hz.hang_err), 64'd0);
    apply(); tick();
    check("wd_hang", 64'(hz.hang_err), 64'd1);
    check("wd_cnt", 64'(hz.stall_cnt), 64'(WDOG));
    hz.d_cache_stall = 0;
    for (int n = 0; n < 3; n++) begin
      apply(); tick();
    end
    check("wd_sticky", 64'(hz.hang_err), 64'd1);
    do_reset();
    check("wd_rst_clear", 64'(hz.hang_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
